bcd_scan_dec: RTL and testbench
===============================

BCD_SCAN_DEC -- requirements
Module: bcd_scan_dec

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits held and scanned; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles each digit stays selected; legal range >=1.
REQ-003 Parameter BLANK_LEAD, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-004 Ports SHALL be, in order:
- clk  in  1: single clock; all logic on rising edge.
- rst  in  1: reset, synchronous, active-high.
- en  in  1: scan enable.
- load  in  1: capture bcd_in into the shadow register.
- bcd_in  in  4*DIGITS: packed BCD digits; digit k = bcd_in[4k+3:4k], digit 0 least significant.
- dec_out  out  10: one-hot decimal code of the selected digit; bit n high means value n.
- dig_sel  out  DIGITS: one-hot select of the digit driving dec_out.
- err  out  DIGITS: per-digit invalid-code flags, bit k for shadow digit k.

Function
REQ-005 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-006 On a clock edge with load=1 (and rst=0), the shadow register SHALL take bcd_in, and err[k] SHALL take 1 iff input digit k > 9, else 0.
REQ-007 Shadow and err SHALL hold their values while load=0; load is honoured regardless of en.
REQ-008 Prescaler width SHALL be $clog2(SCAN_DIV), minimum 1 bit.
REQ-009 With en=1, the prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-010 Digit index idx SHALL advance by 1 on the edge where the prescaler equals SCAN_DIV-1, wrapping DIGITS-1 -> 0.
REQ-011 With SCAN_DIV=1, idx SHALL advance on every enabled cycle.
REQ-012 With en=0, prescaler and idx SHALL hold their values, and dig_sel and dec_out SHALL be registered to all-zero.
REQ-013 With en=1, on each edge dig_sel SHALL be registered to one-hot(idx), using idx as it was before that edge.
REQ-014 With en=1, on each edge dec_out SHALL be registered to decode(shadow[idx]), using pre-edge shadow and idx, giving 1-cycle latency.
REQ-015 decode(v) SHALL be one-hot bit v for v 0..9, and all-zero for v 10..15.
REQ-016 Blanking: if BLANK_LEAD=1, digit k>0 SHALL decode to all-zero when it and every higher digit in the shadow equal 0.
REQ-017 Blanking SHALL leave dig_sel unchanged; digit 0 is never blanked.
REQ-018 Blanking SHALL NOT treat invalid codes (>9) as zero.
REQ-019 When load and the scan advance occur on the same edge, both SHALL take effect; the new shadow value appears on dec_out one edge later.
REQ-020 dig_sel SHALL never have more than one bit set.

Reset
REQ-021 On an edge with rst=1, shadow, err, prescaler, idx, dec_out and dig_sel SHALL all clear to 0.
REQ-022 rst SHALL override load and en on the same edge.
REQ-023 Reset asserted mid-scan SHALL abort the scan; after release, scanning restarts at idx=0 with a full SCAN_DIV period.
REQ-024 After rst deasserts with en=1, the first edge SHALL register dig_sel=0001 and dec_out=decode(digit 0) (0000000001 for zero shadow).

Verification
REQ-025 A bench SHALL cover at least the following directed scenarios, with DIGITS=4 and SCAN_DIV=3 unless stated:
- Load 0x1234, en=1: dig_sel cycles 0001,0010,0100,1000, each for 3 cycles; dec_out shows bits 4,3,2,1 respectively; err=0000.
- Load 0x00A5, BLANK_LEAD=1: digit0 -> bit5; digit1 -> 0 (invalid, not blanked); err=0010; digits 2 and 3 -> all-zero.
- Load 0x0000, BLANK_LEAD=1: only digit 0 shows 0000000001; others all-zero; with BLANK_LEAD=0, all digits show 0000000001.
- Drop en for 5 cycles mid-digit-2: outputs zero, idx and prescaler frozen; on re-enable, digit 2 resumes for its remaining cycles.
- Assert rst together with load=1 and bcd_in=0x9999 during the scan: all outputs 0, shadow stays 0; scan restarts at digit 0.
- SCAN_DIV=1, DIGITS=2: dig_sel alternates 01/10 on every cycle; load on a scan edge is reflected one cycle later.

Source files
------------

// File: rtl/bcd_scan_dec.sv
// Multiplexed BCD display scanner: holds a shadow copy of DIGITS BCD digits,
// steps through them one at a time every SCAN_DIV cycles and presents the
// selected digit as a one-hot decimal code alongside a one-hot digit select.
// Leading zeros can optionally be blanked; invalid codes (>9) are flagged.
module bcd_scan_dec #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned BLANK_LEAD = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [9:0]            dec_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [DIGITS-1:0]     err
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [DIGITS-1:0]   err_q, err_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [9:0]          dec_q, dec_d;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic [DIGITS-1:0]   blank;
   logic                zero_run;
   logic [3:0]          cur_digit;

   // One-hot decimal code; invalid codes decode to nothing.
   function automatic logic [9:0] decode(input logic [3:0] v);
      decode = '0;
      if (v <= 4'd9) begin
         decode = 10'd1 << v;
      end
   endfunction

   // Capture path: new shadow value and per-digit invalid flags on load.
   always_comb begin
      shadow_d = shadow_q;
      err_d    = err_q;
      if (load) begin
         shadow_d = bcd_in;
         for (int k = 0; k < int'(DIGITS); k++) begin
            err_d[k] = (bcd_in[4*k +: 4] > 4'd9);
         end
      end
   end

   // Leading-zero blanking: digit k is blank when it and all higher digits are
   // literally 0. Invalid codes are non-zero, so they break the run naturally.
   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
         zero_run = zero_run & (shadow_q[4*k +: 4] == 4'd0);
         blank[k] = zero_run & (BLANK_LEAD != 0);
      end
   end

   // Scan sequencing and output next-state; everything freezes while en is low.
   always_comb begin
      presc_d   = presc_q;
      idx_d     = idx_q;
      sel_d     = '0;
      dec_d     = '0;
      cur_digit = shadow_q[4*int'(idx_q) +: 4];
      if (en) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
         end else begin
            presc_d = presc_q + PW'(1);
         end
         sel_d = DIGITS'(1) << idx_q;
         dec_d = blank[idx_q] ? 10'd0 : decode(cur_digit);
      end
   end

   // State registers with synchronous reset overriding load and en.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         err_q    <= '0;
         presc_q  <= '0;
         idx_q    <= '0;
         dec_q    <= '0;
         sel_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         err_q    <= err_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         dec_q    <= dec_d;
         sel_q    <= sel_d;
      end
   end

   assign dec_out = dec_q;
   assign dig_sel = sel_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_scan_dec.sv
// Scoreboard bench for bcd_scan_dec: two instances (4 digits / div 3 / blanking,
// and 2 digits / div 1 / no blanking) share stimulus. A behavioural model
// derives the selected digit from the count of enabled cycles since reset.
module tb_bcd_scan_dec;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] bcd_in;
   logic [9:0]  dec_a, dec_b;
   logic [3:0]  sel_a, err_a;
   logic [1:0]  sel_b, err_b;

   typedef struct {
      logic [9:0] dec_a;
      logic [3:0] sel_a;
      logic [3:0] err_a;
      logic [9:0] dec_b;
      logic [1:0] sel_b;
      logic [1:0] err_b;
   } exp_t;

   exp_t        sb[$];
   int          tests;
   int          fails;
   logic [31:0] sh_a, sh_b;
   int          cnt_a, cnt_b;

   bcd_scan_dec #(.DIGITS(4), .SCAN_DIV(3), .BLANK_LEAD(1)) u_a (
      .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
      .dec_out(dec_a), .dig_sel(sel_a), .err(err_a)
   );

   bcd_scan_dec #(.DIGITS(2), .SCAN_DIV(1), .BLANK_LEAD(0)) u_b (
      .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in[7:0]),
      .dec_out(dec_b), .dig_sel(sel_b), .err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] nib(input logic [31:0] v, input int k);
      nib = 4'((v >> (4 * k)) & 32'hF);
   endfunction

   // Displayed code for digit idx of shadow sh.
   function automatic logic [9:0] exp_dec(input logic [31:0] sh, input int n, input int idx,
                                          input bit blk);
      bit all_zero;
      logic [3:0] v;
      v = nib(sh, idx);
      if (blk && idx > 0) begin
         all_zero = 1'b1;
         for (int j = idx; j < n; j++) if (nib(sh, j) != 4'd0) all_zero = 1'b0;
         if (all_zero) return 10'd0;
      end
      return (v <= 4'd9) ? (10'd1 << v) : 10'd0;
   endfunction

   function automatic logic [7:0] exp_err(input logic [31:0] sh, input int n);
      exp_err = '0;
      for (int k = 0; k < n; k++) exp_err[k] = (nib(sh, k) > 4'd9);
   endfunction

   // Outputs after one edge, for one instance.
   task automatic model_step(input bit r, input bit e, input bit l, input logic [31:0] b,
                             input int n, input int sd, input bit blk,
                             inout logic [31:0] sh, inout int cnt,
                             output logic [9:0] dec, output logic [7:0] sel,
                             output logic [7:0] er);
      int idx;
      dec = '0;
      sel = '0;
      if (r) begin
         sh  = '0;
         cnt = 0;
      end else begin
         if (e) begin
            idx = (cnt / sd) % n;
            sel = 8'd1 << idx;
            dec = exp_dec(sh, n, idx, blk);
            cnt++;
         end
         if (l) sh = b;
      end
      er = exp_err(sh, n);
   endtask

   task automatic step(input bit r, input bit e, input bit l, input logic [15:0] b);
      exp_t x;
      logic [7:0] s8, e8;
      @(negedge clk);
      rst    = r;
      en     = e;
      load   = l;
      bcd_in = b;
      model_step(r, e, l, {16'd0, b}, 4, 3, 1'b1, sh_a, cnt_a, x.dec_a, s8, e8);
      x.sel_a = s8[3:0];
      x.err_a = e8[3:0];
      model_step(r, e, l, {24'd0, b[7:0]}, 2, 1, 1'b0, sh_b, cnt_b, x.dec_b, s8, e8);
      x.sel_b = s8[1:0];
      x.err_b = e8[1:0];
      sb.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are registered every edge, so each edge presents one result.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("dec_a", 32'(dec_a), 32'(x.dec_a));
            chk("sel_a", 32'(sel_a), 32'(x.sel_a));
            chk("err_a", 32'(err_a), 32'(x.err_a));
            chk("dec_b", 32'(dec_b), 32'(x.dec_b));
            chk("sel_b", 32'(sel_b), 32'(x.sel_b));
            chk("err_b", 32'(err_b), 32'(x.err_b));
         end
      end
   end

   initial begin
      logic [15:0] rb;
      tests  = 0;
      fails  = 0;
      sh_a   = '0;
      sh_b   = '0;
      cnt_a  = 0;
      cnt_b  = 0;
      rst    = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      bcd_in = '0;

      // 0x1234 full rotation
      repeat (2) step(1, 0, 0, 16'h0);
      step(0, 0, 1, 16'h1234);
      repeat (13) step(0, 1, 0, 16'h0);

      // invalid digit 1, leading zeros above it
      step(1, 0, 0, 16'h0);
      step(0, 0, 1, 16'h00A5);
      repeat (12) step(0, 1, 0, 16'h0);

      // all zero shadow
      step(1, 0, 0, 16'h0);
      step(0, 0, 1, 16'h0000);
      repeat (12) step(0, 1, 0, 16'h0);

      // freeze mid digit 2, then resume
      step(1, 0, 0, 16'h0);
      step(0, 0, 1, 16'h5678);
      repeat (7) step(0, 1, 0, 16'h0);
      repeat (5) step(0, 0, 0, 16'h0);
      repeat (8) step(0, 1, 0, 16'h0);

      // reset with load mid-scan, then restart from digit 0
      repeat (2) step(0, 1, 0, 16'h0);
      step(1, 1, 1, 16'h9999);
      repeat (6) step(0, 1, 0, 16'h0);

      // load coinciding with scan advance
      step(0, 1, 1, 16'h0987);
      repeat (4) step(0, 1, 0, 16'h0);
      step(0, 1, 1, 16'h0F31);
      repeat (4) step(0, 1, 0, 16'h0);

      // random traffic, zero-biased digits to exercise blanking
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 4; k++) begin
            rb[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         end
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 4) == 0), rb);
      end

      repeat (3) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
